// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared frame-buffer packet constants and sequencer state encoding
//
// Purpose: constants shared by the frame-buffer sequencer, the image feeder and the
//          overlay generators, so every block agrees on the packet layout.
// Contents:
//   PKT_W               packet width {mask[3:0], frame, addr[16:0], pixel[31:0]}
//   MASK_*/FRAME_BIT/
//   ADDR_*/PIXEL_*      field offsets inside a packet
//   seq_state_t         sequencer FSM encoding
//   owns_port()         true in the states where the selected source drives the port
package fb_pkg;

  localparam int PKT_W     = 54;
  localparam int MASK_MSB  = 53;
  localparam int MASK_LSB  = 50;
  localparam int FRAME_BIT = 49;
  localparam int ADDR_MSB  = 48;
  localparam int ADDR_LSB  = 32;
  localparam int PIXEL_MSB = 31;
  localparam int PIXEL_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_ACK   = 3'd4,
    ST_FIN   = 3'd5
  } seq_state_t;

  // The port stays with the selected source from its start request until its
  // done handshake completes, so late-start beats are routed too.
  function automatic logic owns_port(seq_state_t s);
    return (s == ST_START) || (s == ST_RUN) || (s == ST_ACK);
  endfunction

endpackage

// File: rtl/fb_source_sequencer_if.sv
// rtl/fb_source_sequencer_if.sv - source handshake and packet stream bundle of the sequencer
//
// Purpose: groups the per-source start/done handshakes, the per-source packet streams
//          and the single frame-buffer writer stream.
// Signals:
//   start / start_ack     per-source start request level and its acknowledge
//   done / done_ack       per-source done level and its acknowledge
//   src_dout/valid/ready  packed per-source packets (source i at [i*PKT_W +: PKT_W])
//   fb_dout/valid/ready   packet stream to the frame-buffer writer
// Modports:
//   master  the sequencer
//   slave   the environment (sources plus writer)
interface fb_source_sequencer_if #(
  parameter int N_SRC = 2,
  parameter int PKT_W = fb_pkg::PKT_W
);

  logic [N_SRC-1:0]       start;
  logic [N_SRC-1:0]       start_ack;
  logic [N_SRC-1:0]       done;
  logic [N_SRC-1:0]       done_ack;
  logic [N_SRC*PKT_W-1:0] src_dout;
  logic [N_SRC-1:0]       src_valid;
  logic [N_SRC-1:0]       src_ready;
  logic [PKT_W-1:0]       fb_dout;
  logic                   fb_valid;
  logic                   fb_ready;

  modport master (
    output start, done_ack, src_ready, fb_dout, fb_valid,
    input  start_ack, done, src_dout, src_valid, fb_ready
  );

  modport slave (
    input  start, done_ack, src_ready, fb_dout, fb_valid,
    output start_ack, done, src_dout, src_valid, fb_ready
  );

endinterface

// File: rtl/fb_source_sequencer_mux.sv
// rtl/fb_source_sequencer_mux.sv - combinational owner-select packet mux and ready demux
//
// Purpose: forwards the owning source's packet stream to the frame-buffer writer with
//          zero latency and returns the writer's ready to that source only.
// Ports:
//   owner_oh   in   N_SRC        one-hot owner, all zero when nobody owns the port
//   src_dout   in   N_SRC*PKT_W  packed source packets
//   src_valid  in   N_SRC        source valids
//   src_ready  out  N_SRC        source readies (only the owner can see fb_ready)
//   fb_dout    out  PKT_W        owner packet, zero when no owner
//   fb_valid   out  1            owner valid, zero when no owner
//   fb_ready   in   1            writer ready
module fb_stream_mux #(
  parameter int N_SRC = 2,
  parameter int PKT_W = fb_pkg::PKT_W
) (
  input  logic [N_SRC-1:0]       owner_oh,
  input  logic [N_SRC*PKT_W-1:0] src_dout,
  input  logic [N_SRC-1:0]       src_valid,
  output logic [N_SRC-1:0]       src_ready,
  output logic [PKT_W-1:0]       fb_dout,
  output logic                   fb_valid,
  input  logic                   fb_ready
);

  // AND-OR select: with a one-hot (or empty) owner this is a plain mux and
  // produces all zeros when nobody owns the port.
  always_comb begin
    fb_dout = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (owner_oh[i]) begin
        fb_dout = fb_dout | src_dout[i*PKT_W +: PKT_W];
      end
    end
  end

  assign fb_valid  = |(src_valid & owner_oh);
  assign src_ready = owner_oh & {N_SRC{fb_ready}};

endmodule

// File: rtl/fb_source_sequencer.sv
// rtl/fb_source_sequencer.sv - runs every enabled pixel source in turn on the frame-buffer port
//
// Purpose: on each frame request, visits every enabled source in index order, performs
//          its start handshake, routes its packets to the frame-buffer writer, performs
//          its done handshake, then pulses frame_done. Unresponsive sources time out.
// Ports:
//   clock, reset  clock and synchronous active-high reset
//   frame_req     one-cycle request for a frame sequence
//   src_en        per-source enable, sampled when the source's slot is reached
//   bus           handshake/stream bundle (master side)
//   busy          high outside IDLE
//   active        index of the source currently owning the port
//   frame_done    one-cycle pulse at the end of a sequence
//   err           sticky per-source timeout flags
//   overrun       sticky: a request was dropped because one was already pending
module fb_source_sequencer #(
  parameter int N_SRC    = 2,
  parameter int PKT_W    = fb_pkg::PKT_W,
  parameter int START_TO = 64,
  parameter int DONE_TO  = 1048576
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        frame_req,
  input  logic [N_SRC-1:0]            src_en,
  fb_source_sequencer_if.master       bus,
  output logic                        busy,
  output logic [1:0]                  active,
  output logic                        frame_done,
  output logic [N_SRC-1:0]            err,
  output logic                        overrun
);

  import fb_pkg::*;

  localparam int TW = $clog2(DONE_TO) + 1;
  // idx must be able to reach N_SRC, the "all sources visited" value.
  localparam int IW = $clog2(N_SRC + 1);

  localparam logic [TW-1:0] START_LAST = TW'(START_TO - 1);
  localparam logic [TW-1:0] DONE_LAST  = TW'(DONE_TO - 1);
  localparam logic [IW-1:0] IDX_END    = IW'(N_SRC);

  seq_state_t       state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [TW-1:0]    timer;
  logic             pending;
  logic             timeout;

  logic [N_SRC-1:0] sel_oh;
  logic [N_SRC-1:0] owner_oh;
  logic             en_hit, ack_hit, done_hit;

  // One-hot of the slot being visited; shifts out to zero when idx == N_SRC,
  // which keeps every per-source lookup in range without a separate guard.
  assign sel_oh   = N_SRC'(1) << idx;
  assign en_hit   = |(src_en        & sel_oh);
  assign ack_hit  = |(bus.start_ack & sel_oh);
  assign done_hit = |(bus.done      & sel_oh);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_req || pending) begin
          state_n = ST_SEL;
          idx_n   = '0;
        end
      end
      ST_SEL: begin
        if (idx == IDX_END) begin
          state_n = ST_FIN;
        end else if (!en_hit) begin
          idx_n = idx + IW'(1);
        end else begin
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (ack_hit) begin
          state_n = ST_RUN;
        end else if (timer == START_LAST) begin
          timeout = 1'b1;
          idx_n   = idx + IW'(1);
          state_n = ST_SEL;
        end
      end
      ST_RUN: begin
        if (done_hit) begin
          state_n = ST_ACK;
        end else if (timer == DONE_LAST) begin
          // Abandoned source: no done_ack is ever issued to it.
          timeout = 1'b1;
          idx_n   = idx + IW'(1);
          state_n = ST_SEL;
        end
      end
      ST_ACK: begin
        if (!done_hit) begin
          idx_n   = idx + IW'(1);
          state_n = ST_SEL;
        end
      end
      ST_FIN: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      timer   <= '0;
      pending <= 1'b0;
      err     <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;

      // Timers only run while waiting on a source and restart on every state entry.
      if ((state_n != state) || !((state_n == ST_START) || (state_n == ST_RUN))) begin
        timer <= '0;
      end else begin
        timer <= timer + TW'(1);
      end

      if (timeout) begin
        err <= err | sel_oh;
      end

      // IDLE always consumes the pending request. FIN counts as busy, so a
      // request there is queued and picked up by the following IDLE cycle.
      if (state == ST_IDLE) begin
        pending <= 1'b0;
      end else if (frame_req) begin
        if (pending) begin
          overrun <= 1'b1;
        end else begin
          pending <= 1'b1;
        end
      end
    end
  end

  assign owner_oh     = owns_port(state) ? sel_oh : '0;
  assign bus.start    = (state == ST_START) ? sel_oh : '0;
  assign bus.done_ack = (state == ST_ACK)   ? sel_oh : '0;
  assign busy         = (state != ST_IDLE);
  assign frame_done   = (state == ST_FIN);

  always_comb begin
    active = 2'd0;
    if (state != ST_IDLE) begin
      active = (idx == IDX_END) ? 2'(N_SRC - 1) : 2'(idx);
    end
  end

  fb_stream_mux #(
    .N_SRC (N_SRC),
    .PKT_W (PKT_W)
  ) u_mux (
    .owner_oh  (owner_oh),
    .src_dout  (bus.src_dout),
    .src_valid (bus.src_valid),
    .src_ready (bus.src_ready),
    .fb_dout   (bus.fb_dout),
    .fb_valid  (bus.fb_valid),
    .fb_ready  (bus.fb_ready)
  );

endmodule

// File: tb/tb_fb_source_sequencer.sv
// tb/tb_fb_source_sequencer.sv - self-checking bench for fb_source_sequencer
module tb_fb_source_sequencer;
  import fb_pkg::*;

  localparam int N  = 2;
  localparam int PW = PKT_W;
  localparam int NB = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         frame_req = 1'b0;
  logic [N-1:0] src_en = '0;
  logic         busy;
  logic [1:0]   active;
  logic         frame_done;
  logic [N-1:0] err;
  logic         overrun;

  fb_source_sequencer_if #(.N_SRC(N), .PKT_W(PW)) bus ();

  fb_source_sequencer #(
    .N_SRC(N), .PKT_W(PW), .START_TO(64), .DONE_TO(1048576)
  ) dut (
    .clock(clock), .reset(reset), .frame_req(frame_req), .src_en(src_en),
    .bus(bus), .busy(busy), .active(active), .frame_done(frame_done),
    .err(err), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] beat(input int s, input int k);
    logic [PW-1:0] b;
    b = '0;
    b[53:50] = 4'(s + 1);
    b[49]    = k[0];
    b[48:32] = 17'(k * 3 + s);
    b[31:0]  = 32'hA000_0000 + 32'(s * 256 + k);
    return b;
  endfunction

  typedef struct {
    int            src;
    logic [PW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Source model state: phase 0 idle, 1 streaming, 2 done raised.
  int           ph[N];
  int           sent[N];
  logic [N-1:0] ack_en = '0;
  logic         tog = 1'b0;
  logic [N-1:0] acc = '0;

  int            fd_cnt = 0;
  int            start_cnt[N];
  int            acc_cnt = 0;
  int            r1_bad = 0;
  logic [PW-1:0] first_beat = '0;
  bit            got_first = 0;

  // Reactive sources: ack start in the cycle it is seen, stream NB beats, raise
  // done, drop done once done_ack is seen.
  initial begin : drv
    logic rs;
    for (int i = 0; i < N; i++) begin ph[i] = 0; sent[i] = 0; start_cnt[i] = 0; end
    bus.start_ack = '0; bus.done = '0; bus.src_valid = '0; bus.src_dout = '0;
    bus.fb_ready = 1'b1;
    forever begin
      @(posedge clock);
      rs = reset;
      #1;
      if (rs) begin
        for (int i = 0; i < N; i++) begin ph[i] = 0; sent[i] = 0; end
        bus.start_ack = '0; bus.done = '0; bus.src_valid = '0; bus.src_dout = '0;
      end else begin
        bus.fb_ready  = tog ? ~bus.fb_ready : 1'b1;
        bus.start_ack = '0;
        for (int i = 0; i < N; i++) begin
          if (acc[i]) sent[i]++;
          if (ph[i] == 2) begin
            if (bus.done_ack[i]) begin bus.done[i] = 1'b0; ph[i] = 0; end
          end else begin
            if (ph[i] == 0 && bus.start[i] && ack_en[i]) begin
              bus.start_ack[i] = 1'b1; ph[i] = 1; sent[i] = 0;
            end
            if (ph[i] == 1) begin
              if (sent[i] < NB) begin
                bus.src_valid[i] = 1'b1;
                bus.src_dout[i*PW +: PW] = beat(i, sent[i]);
              end else begin
                bus.src_valid[i] = 1'b0; bus.done[i] = 1'b1; ph[i] = 2;
              end
            end
          end
        end
      end
    end
  end

  // Compare process: every accepted writer beat must be the next expected beat of
  // the expected owner; with the sequencer idle, nothing may be routed or requested.
  always @(negedge clock) begin : mon
    exp_t e;
    acc = bus.src_valid & bus.src_ready;
    if (!reset) begin
      if (frame_done) fd_cnt++;
      for (int i = 0; i < N; i++) if (bus.start[i]) start_cnt[i]++;
      if (bus.src_ready[1] && ph[0] != 0) r1_bad++;
      if (bus.fb_valid && bus.fb_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'(bus.fb_dout), 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 64'(bus.fb_dout), 64'(e.data));
          check("beat_owner", 64'(active), 64'(e.src));
          acc_cnt++;
          if (!got_first) begin first_beat = bus.fb_dout; got_first = 1; end
        end
      end
      if (!busy) begin
        check("idle_route", 64'({bus.fb_valid, bus.src_ready, bus.start, bus.done_ack, active}), 64'h0);
        check("idle_dout", 64'(bus.fb_dout), 64'h0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    fd_cnt = 0; acc_cnt = 0; r1_bad = 0; got_first = 0;
    for (int i = 0; i < N; i++) start_cnt[i] = 0;
  endtask

  task automatic do_reset();
    frame_req = 1'b0; tog = 1'b0;
    reset = 1'b1;
    tick(2);
    clear_model();
    reset = 1'b0;
  endtask

  task automatic setup(input logic [N-1:0] en, input logic [N-1:0] acks, input logic t, input int frames);
    exp_t e;
    src_en = en; ack_en = acks; tog = t;
    for (int f = 0; f < frames; f++)
      for (int i = 0; i < N; i++)
        if (en[i] && acks[i])
          for (int k = 0; k < NB; k++) begin e.src = i; e.data = beat(i, k); exp_q.push_back(e); end
  endtask

  task automatic pulse_req();
    frame_req = 1'b1;
    tick(1);
    frame_req = 1'b0;
  endtask

  task automatic wait_fd(input int n, input int budget);
    int c = 0;
    while (fd_cnt < n && c < budget) begin tick(1); c++; end
    if (fd_cnt < n) check("frame_done_timeout", 64'(fd_cnt), 64'(n));
  endtask

  task automatic end_checks(input string tag, input logic [N-1:0] exp_err, input int exp_fd,
                            input int exp_beats, input int exp_start0, input logic exp_ovr);
    tick(4);
    check({tag, "_leftover"}, 64'(exp_q.size()), 64'h0);
    check({tag, "_frame_done"}, 64'(fd_cnt), 64'(exp_fd));
    check({tag, "_beats"}, 64'(acc_cnt), 64'(exp_beats));
    check({tag, "_start0_cycles"}, 64'(start_cnt[0]), 64'(exp_start0));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_overrun"}, 64'(overrun), 64'(exp_ovr));
    check({tag, "_busy"}, 64'(busy), 64'h0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    tick(3);
    check("rst_status", 64'({busy, active, frame_done, err, overrun}), 64'h0);
    check("rst_bus", 64'({bus.start, bus.done_ack, bus.src_ready, bus.fb_valid}), 64'h0);
    reset = 1'b0;

    // 1: both sources, prompt acks, 4 beats each.
    do_reset();
    setup(2'b11, 2'b11, 1'b0, 1);
    pulse_req();
    wait_fd(1, 400);
    end_checks("t1", 2'b00, 1, 8, 1, 1'b0);
    check("t1_start1_cycles", 64'(start_cnt[1]), 64'd1);
    check("t1_first_beat", 64'(first_beat), 64'h4_0000_A000_0000);

    // 2: source 0 disabled.
    do_reset();
    setup(2'b10, 2'b11, 1'b0, 1);
    pulse_req();
    wait_fd(1, 400);
    end_checks("t2", 2'b00, 1, 4, 0, 1'b0);

    // 4: writer ready toggles every cycle.
    do_reset();
    setup(2'b11, 2'b11, 1'b1, 1);
    pulse_req();
    wait_fd(1, 600);
    end_checks("t4", 2'b00, 1, 8, 1, 1'b0);
    check("t4_ready1_during_src0", 64'(r1_bad), 64'h0);

    // 3: source 0 never acknowledges start.
    do_reset();
    setup(2'b11, 2'b10, 1'b0, 1);
    pulse_req();
    wait_fd(1, 600);
    end_checks("t3", 2'b01, 1, 4, 64, 1'b0);
    check("t3_first_beat", 64'(first_beat), 64'h8_0001_A000_0100);

    // 5: two extra requests during a busy frame.
    do_reset();
    setup(2'b11, 2'b11, 1'b0, 2);
    pulse_req();
    tick(3);
    pulse_req();
    tick(3);
    pulse_req();
    wait_fd(2, 800);
    end_checks("t5", 2'b00, 2, 16, 2, 1'b1);

    // 6: reset mid-stream clears everything, including the sticky overrun.
    clear_model();
    setup(2'b11, 2'b11, 1'b0, 1);
    pulse_req();
    begin
      int c = 0;
      while (acc_cnt < 2 && c < 50) begin tick(1); c++; end
      if (acc_cnt < 2) check("t6_stream_timeout", 64'(acc_cnt), 64'd2);
    end
    check("t6_src0_streaming", 64'(ph[0]), 64'd1);
    reset = 1'b1;
    tick(1);
    check("t6_bus", 64'({bus.start, bus.done_ack, bus.src_ready, bus.fb_valid}), 64'h0);
    check("t6_busy", 64'(busy), 64'h0);
    check("t6_overrun", 64'(overrun), 64'h0);
    check("t6_err", 64'(err), 64'h0);
    clear_model();
    reset = 1'b0;
    tick(3);
    check("t6_idle_after", 64'({busy, frame_done, active}), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
